// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS quarter-wave LUT sequencer.
// Defines FSM states, polarity codes, quadrant codes and default widths.
package dds_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 7;
  localparam int PHASE_W_DEF = 10;
  localparam int OUT_W_DEF   = 8;
  localparam int MIDSCALE    = 1 << (OUT_W_DEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_FETCH   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  typedef enum logic {
    POL_POS = 1'b0,
    POL_NEG = 1'b1
  } pol_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  function automatic int midscale_of(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with phase load and per-sample step add.
// Decodes the quarter-wave LUT address and output polarity from the current phase.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_phase,
  input  logic               advance,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] step,
  output logic [ADDR_W-1:0]  addr,
  output pol_t               pol
);

  logic [PHASE_W-1:0] acc;
  quad_t              q;
  logic [ADDR_W-1:0]  idx;

  // A phase load wins over a same-cycle step add.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (set_phase) begin
      acc <= phase;
    end else if (advance) begin
      acc <= acc + step;
    end
  end

  always_comb begin
    q    = quad_t'(acc[PHASE_W-1 -: 2]);
    idx  = acc[ADDR_W-1:0];
    addr = idx;
    pol  = POL_POS;
    case (q)
      Q0: addr = idx;
      Q1: addr = ~idx;
      Q2: pol = POL_NEG;
      Q3: begin
        addr = ~idx;
        pol  = POL_NEG;
      end
      default: addr = idx;
    endcase
  end

endmodule

// File: rtl/dds_seq_ctrl.sv
// DDS sequencer: arbitrates the single-port sine LUT between host writes and
// per-tick playback fetches, and forms the offset-binary sine output.
module dds_seq_ctrl
  import dds_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               src_clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               tick,
  input  logic               set_phase,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] step,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_ack,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [OUT_W-1:0]   sinwave,
  output logic               sample_valid,
  output logic               miss,
  output logic [1:0]         dbg_state
);

  localparam logic [OUT_W-1:0] MID = OUT_W'(midscale_of(OUT_W));

  state_t            state, next_state;
  logic              pending, pending_next, miss_next;
  logic              write_go, fetch_go, tick_en, tick_defer;
  logic [ADDR_W-1:0] lut_addr;
  pol_t              lut_pol, pol_q;
  logic [OUT_W-1:0]  mag;

  dds_phase_acc #(
    .ADDR_W (ADDR_W),
    .PHASE_W(PHASE_W)
  ) u_acc (
    .clk      (src_clk),
    .rst      (rst),
    .set_phase(set_phase),
    .advance  (fetch_go),
    .phase    (phase),
    .step     (step),
    .addr     (lut_addr),
    .pol      (lut_pol)
  );

  assign tick_en   = tick & ena;
  assign mag       = OUT_W'(mem_rdata);
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    write_go   = 1'b0;
    fetch_go   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_req) begin
          next_state = ST_WRITE;
          write_go   = 1'b1;
        end else if (tick_en || pending) begin
          next_state = ST_FETCH;
          fetch_go   = 1'b1;
        end
      end
      ST_WRITE:   next_state = ST_IDLE;
      ST_FETCH:   next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // A tick that cannot start a fetch is parked in the one-deep pending slot.
  // If a fetch serves the pending sample while a fresh tick arrives, the
  // fresh tick takes over the slot so no tick is lost silently.
  always_comb begin
    tick_defer   = tick_en && ((state != ST_IDLE) || wr_req);
    pending_next = pending;
    miss_next    = 1'b0;
    if (tick_defer) begin
      if (pending) miss_next = 1'b1;
      else         pending_next = 1'b1;
    end else if (fetch_go) begin
      pending_next = pending && tick_en;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      miss         <= 1'b0;
      wr_ack       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pol_q        <= POL_POS;
      sinwave      <= MID;
      sample_valid <= 1'b0;
    end else begin
      state        <= next_state;
      pending      <= pending_next;
      miss         <= miss_next;
      wr_ack       <= write_go;
      mem_we       <= write_go;
      sample_valid <= (state == ST_CAPTURE);
      if (write_go) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (fetch_go) begin
        mem_addr <= lut_addr;
        pol_q    <= lut_pol;
      end
      if (state == ST_CAPTURE) begin
        sinwave <= (pol_q == POL_POS) ? (MID + mag) : (MID - mag);
      end
    end
  end

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Bench for dds_seq_ctrl: table-driven playback vectors, directed corner
// sequences, and randomized traffic checked against a phase/LUT reference model.
module tb_dds_seq_ctrl;

  logic        src_clk;
  logic        rst;
  logic        ena;
  logic        tick;
  logic        set_phase;
  logic [9:0]  phase;
  logic [9:0]  step;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [6:0]  wr_data;
  logic        wr_ack;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [6:0]  mem_wdata;
  logic [6:0]  mem_rdata;
  logic [7:0]  sinwave;
  logic        sample_valid;
  logic        miss;
  logic [1:0]  dbg_state;

  dds_seq_ctrl dut (
    .src_clk     (src_clk),
    .rst         (rst),
    .ena         (ena),
    .tick        (tick),
    .set_phase   (set_phase),
    .phase       (phase),
    .step        (step),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .sinwave     (sinwave),
    .sample_valid(sample_valid),
    .miss        (miss),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial begin
    src_clk = 1'b0;
    forever #5 src_clk = ~src_clk;
  end

  // LUT RAM: single port, 1-cycle read latency
  logic [6:0] lut [256];
  logic [6:0] rdata_r;
  always @(posedge src_clk) begin
    if (mem_we) lut[mem_addr] <= mem_wdata;
    rdata_r <= lut[mem_addr];
  end
  assign mem_rdata = rdata_r;

  // reference model state
  logic [6:0] lut_ref [256];
  int         m_acc;
  int         m_step;
  logic [7:0] exp_q[$];
  bit         sb_on;

  int n_tests, n_fail;
  int sv_cnt, miss_cnt, we_cnt, ack_cnt, fetch_cnt;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] sin;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_sample(input int acc);
    int q, idx, a, mag;
    q   = acc / 256;
    idx = acc % 256;
    a   = (q % 2 == 1) ? (255 - idx) : idx;
    mag = int'(lut_ref[a]);
    return (q < 2) ? 8'(128 + mag) : 8'(128 - mag);
  endfunction

  task automatic step_clk();
    @(posedge src_clk);
    #1;
    if (sample_valid) sv_cnt++;
    if (miss) miss_cnt++;
    if (mem_we) we_cnt++;
    if (wr_ack) ack_cnt++;
    if (dbg_state == 2'd2) fetch_cnt++;
    if (sb_on && sample_valid) begin
      if (exp_q.size() == 0) check("rand_unexpected_sample", 32'(sample_valid), 0);
      else check("rand_sample", 32'(sinwave), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic clear_counts();
    sv_cnt = 0; miss_cnt = 0; we_cnt = 0; ack_cnt = 0; fetch_cnt = 0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [6:0] d);
    int k;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    k = 0;
    do begin
      step_clk();
      k++;
    end while (!wr_ack && k < 10);
    check("write_ack_seen", 32'(wr_ack), 1);
    wr_req = 1'b0;
    lut_ref[a] = d;
    step_clk();
  endtask

  task automatic load_phase(input int p);
    set_phase = 1'b1; phase = 10'(p);
    step_clk();
    set_phase = 1'b0;
    m_acc = p;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step_clk();
    tick = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; sb_on = 1'b0;
    clear_counts();
    for (int i = 0; i < 256; i++) begin
      lut[i]     = 7'(i >> 1);
      lut_ref[i] = 7'(i >> 1);
    end
    rst = 1'b1; ena = 1'b0; tick = 1'b0; set_phase = 1'b0; phase = '0;
    step = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    m_acc = 0; m_step = 0;

    // playback table: step 64 from acc 0, LUT[i] = i>>1
    vecs[0]  = '{8'd0,   8'd128}; vecs[1]  = '{8'd64,  8'd160};
    vecs[2]  = '{8'd128, 8'd192}; vecs[3]  = '{8'd192, 8'd224};
    vecs[4]  = '{8'd255, 8'd255}; vecs[5]  = '{8'd191, 8'd223};
    vecs[6]  = '{8'd127, 8'd191}; vecs[7]  = '{8'd63,  8'd159};
    vecs[8]  = '{8'd0,   8'd128}; vecs[9]  = '{8'd64,  8'd96};
    vecs[10] = '{8'd128, 8'd64};  vecs[11] = '{8'd192, 8'd32};
    vecs[12] = '{8'd255, 8'd1};   vecs[13] = '{8'd191, 8'd33};
    vecs[14] = '{8'd127, 8'd65};  vecs[15] = '{8'd63,  8'd97};

    // reset state
    step_clk(); step_clk();
    rst = 1'b0;
    check("rst_sinwave", 32'(sinwave), 128);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_wr_ack", 32'(wr_ack), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_miss", 32'(miss), 0);
    check("rst_state", 32'(dbg_state), 0);

    // table-driven playback, one tick every 10 cycles
    ena = 1'b1; step = 10'd64;
    for (int i = 0; i < 16; i++) begin
      pulse_tick();
      check("tbl_mem_addr", 32'(mem_addr), 32'(vecs[i].addr));
      check("tbl_sv_early1", 32'(sample_valid), 0);
      step_clk();
      check("tbl_sv_early2", 32'(sample_valid), 0);
      step_clk();
      check("tbl_sv_at3", 32'(sample_valid), 1);
      check("tbl_sinwave", 32'(sinwave), 32'(vecs[i].sin));
      for (int j = 0; j < 7; j++) step_clk();
      check("tbl_sinwave_hold", 32'(sinwave), 32'(vecs[i].sin));
    end

    // phase load to 768: mirrored address, negative half
    load_phase(768);
    pulse_tick();
    check("ph_mem_addr", 32'(mem_addr), 255);
    step_clk(); step_clk();
    check("ph_sv", 32'(sample_valid), 1);
    check("ph_sinwave", 32'(sinwave), 1);
    step_clk(); step_clk();

    // write and tick in the same cycle: write first, sample one cycle late
    clear_counts();
    wr_req = 1'b1; wr_addr = 8'd5; wr_data = 7'd100; tick = 1'b1;
    step_clk();
    tick = 1'b0;
    check("wt_wr_ack", 32'(wr_ack), 1);
    check("wt_mem_we", 32'(mem_we), 1);
    check("wt_mem_addr", 32'(mem_addr), 5);
    check("wt_mem_wdata", 32'(mem_wdata), 100);
    wr_req = 1'b0; lut_ref[5] = 7'd100;
    step_clk();
    check("wt_we_off", 32'(mem_we), 0);
    check("wt_ack_off", 32'(wr_ack), 0);
    step_clk();
    check("wt_fetch_addr", 32'(mem_addr), 191);
    step_clk();
    check("wt_sv_early", 32'(sample_valid), 0);
    step_clk();
    check("wt_sv", 32'(sample_valid), 1);
    check("wt_sinwave", 32'(sinwave), 33);
    check("wt_no_miss", 32'(miss_cnt), 0);
    step_clk();
    load_phase(5);
    pulse_tick();
    step_clk(); step_clk();
    check("wt_readback", 32'(sinwave), 228);
    step_clk();

    // three back-to-back ticks: accept, pend, miss
    load_phase(0);
    clear_counts();
    tick = 1'b1;
    step_clk(); step_clk(); step_clk();
    tick = 1'b0;
    check("bb_miss_pulse", 32'(miss), 1);
    for (int i = 0; i < 10; i++) step_clk();
    check("bb_sv_count", 32'(sv_cnt), 2);
    check("bb_miss_count", 32'(miss_cnt), 1);

    // ena low: ticks ignored, write still served, output held
    begin
      logic [7:0] held;
      held = sinwave;
      clear_counts();
      ena = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick = 1'($urandom_range(0, 1));
        if (i == 3) begin
          wr_req = 1'b1; wr_addr = 8'd10; wr_data = 7'd7;
        end
        step_clk();
        if (wr_ack) wr_req = 1'b0;
      end
      tick = 1'b0; wr_req = 1'b0; lut_ref[10] = 7'd7;
      check("dis_fetch_count", 32'(fetch_cnt), 0);
      check("dis_sv_count", 32'(sv_cnt), 0);
      check("dis_miss_count", 32'(miss_cnt), 0);
      check("dis_we_count", 32'(we_cnt), 1);
      check("dis_ack_count", 32'(ack_cnt), 1);
      check("dis_sinwave_hold", 32'(sinwave), 32'(held));
      ena = 1'b1;
    end

    // reset during CAPTURE
    load_phase(300);
    pulse_tick();
    check("rc_pre_addr", 32'(mem_addr), 211);
    step_clk();
    check("rc_in_capture", 32'(dbg_state), 3);
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    check("rc_sinwave", 32'(sinwave), 128);
    check("rc_sv", 32'(sample_valid), 0);
    check("rc_state", 32'(dbg_state), 0);
    check("rc_mem_addr", 32'(mem_addr), 0);
    step_clk();
    check("rc_sv_after", 32'(sample_valid), 0);
    pulse_tick();
    check("rc_acc_zero", 32'(mem_addr), 0);
    step_clk(); step_clk(); step_clk();

    // randomized sparse traffic against the reference model
    sb_on = 1'b1;
    load_phase(int'($urandom_range(0, 1023)));
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0)
        do_write(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)));
      if ($urandom_range(0, 4) == 0)
        load_phase(int'($urandom_range(0, 1023)));
      m_step = int'($urandom_range(0, 1023));
      step = 10'(m_step);
      exp_q.push_back(model_sample(m_acc));
      m_acc = (m_acc + m_step) % 1024;
      pulse_tick();
      for (int g = 0; g < int'($urandom_range(4, 8)); g++) step_clk();
    end
    for (int i = 0; i < 6; i++) step_clk();
    check("rand_queue_drained", 32'(exp_q.size()), 0);
    sb_on = 1'b0;

    // dense random ticks: every tick is either sampled or reported missed
    begin
      int n_ticks;
      n_ticks = 0;
      clear_counts();
      for (int i = 0; i < 200; i++) begin
        tick = 1'($urandom_range(0, 1));
        if (tick) n_ticks++;
        step_clk();
      end
      tick = 1'b0;
      for (int i = 0; i < 10; i++) step_clk();
      check("dense_accounting", 32'(sv_cnt + miss_cnt), 32'(n_ticks));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_seq_ctrl.md
Name: dds_seq_ctrl

Overview:
- Sequencer and arbiter for the DDS quarter-wave sine LUT, a single-port synchronous RAM with 1-cycle read latency.
- Runs a phase accumulator and a quadrant mirror/polarity scheme, and fetches one LUT sample per sample tick from the Prescaler.
- Shares the LUT port between playback reads and host table writes.
- Drives the offset-binary sine output.

Parameters:
- ADDR_W, 8: LUT address width. Quarter wave holds 2^ADDR_W entries.
- DATA_W, 7: LUT magnitude width, range 0..127.
- PHASE_W, 10: accumulator width, equal to ADDR_W+2.
- OUT_W, 8: sinwave width. Midscale is 2^(OUT_W-1) = 128.

Ports:
- src_clk, in, 1: sole clock.
- rst, in, 1: synchronous reset, active-high.
- ena, in, 1: playback enable.
- tick, in, 1: 1-cycle sample strobe from the Prescaler.
- set_phase, in, 1: load the phase value into the accumulator.
- phase, in, PHASE_W: phase load value.
- step, in, PHASE_W: tuning word added to the accumulator per sample.
- wr_req, in, 1: host LUT write request. Level signal, held until wr_ack.
- wr_addr, in, ADDR_W: host write address.
- wr_data, in, DATA_W: host write data.
- wr_ack, out, 1: 1-cycle pulse, write performed.
- mem_addr, out, ADDR_W: LUT address (registered).
- mem_we, out, 1: LUT write enable (registered).
- mem_wdata, out, DATA_W: LUT write data (registered).
- mem_rdata, in, DATA_W: LUT read data, valid 1 cycle after its address.
- sinwave, out, OUT_W: sine sample, offset binary.
- sample_valid, out, 1: 1-cycle pulse when sinwave updates.
- miss, out, 1: 1-cycle pulse when a tick is dropped.

Behaviour:
- Reset values: acc=0, state IDLE, pending=0, sinwave=128, sample_valid=0, wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, miss=0.
- Quadrant mapping: q = acc[PHASE_W-1:PHASE_W-2], idx = acc[ADDR_W-1:0].
  - q0: addr=idx, positive.
  - q1: addr=~idx, positive.
  - q2: addr=idx, negative.
  - q3: addr=~idx, negative.
- Output arithmetic: positive gives sinwave = 128 + mag; negative gives 128 - mag. Result range 1..255, no overflow by construction.
- State IDLE:
  - If wr_req: go to WRITE. Writes win over a simultaneous tick or pending sample.
  - Else if (tick & ena) or pending: go to FETCH. Register mem_addr from the current acc, latch polarity, acc <= acc + step (mod 2^PHASE_W), clear pending.
- State WRITE: 1 cycle. mem_we=1 with mem_addr=wr_addr, mem_wdata=wr_data. wr_ack pulses in this cycle. Next state is IDLE. mem_we deasserts on the next edge.
- State FETCH: 1 cycle, memory access in flight. Next state is CAPTURE.
- State CAPTURE: register sinwave from mem_rdata and the latched polarity. sample_valid pulses the cycle after. Next state is IDLE.
- Latency: a tick accepted at edge n gives mem_addr valid after edge n+1. sinwave/sample_valid update at edge n+3.
- Tick arriving while not in IDLE, or coinciding with a granted write:
  - Sets pending if pending=0.
  - If pending=1 already, the tick is dropped and miss pulses.
- ena=0: ticks are ignored (no pending, no miss). An in-flight sample completes. Writes are still served. sinwave holds.
- set_phase: acc <= phase at the next edge, overriding any same-cycle step add. An in-flight sample completes with its old address.
- The host sees a write completed when wr_ack is 1. Max wait is 2 cycles plus the CAPTURE cycle (3 cycles).
- rst mid-operation: all state returns to reset values at once. No partial write is issued after rst is sampled.

Decomposition:
- Shared package dds_pkg holds:
  - state encoding IDLE/WRITE/FETCH/CAPTURE
  - POL_POS/POL_NEG
  - MIDSCALE constant
  - quadrant codes Q0..Q3
- One natural sub-module: dds_phase_acc, containing the accumulator, set_phase load, step add, and the quadrant/addr/polarity decode (combinational outputs). The FSM and arbitration stay in the top.

Test Plan:
- Reset, then step=64, ena=1, one tick every 10 cycles, LUT[i]=i>>1 → mem_addr sequence 0,64,128,192,255,191,... Polarity flips after acc crosses 512. sinwave = 128±LUT value. sample_valid exactly 3 cycles after each tick.
- set_phase=768 with phase load, then a tick → address ~0=255, negative. sinwave = 128 - LUT[255] (LUT[255]=127 gives 1).
- wr_req with addr=5, data=100 in the same cycle as a tick → WRITE first, wr_ack at cycle+1, then FETCH. Sample delayed by 1 cycle. miss=0.
- Three ticks on consecutive cycles → the first is accepted, the second becomes pending, the third pulses miss. Exactly 2 sample_valid pulses.
- ena=0 with ticks applied → no FETCH, sinwave holds. A write during this still acks and mem_we pulses once.
- rst asserted during CAPTURE → next cycle sinwave=128, sample_valid=0, acc=0, state IDLE.
